// File: rtl/conv3x3_mac_if.sv
// Window/kernel input and result output bundle of the 3x3 convolution engine.
// The upstream source uses master, conv3x3_mac uses slave.
interface conv3x3_mac_if;
    logic        [71:0] in_vector;
    logic               in_valid;
    logic signed [7:0]  w_data;
    logic               w_valid;
    logic signed [15:0] bias;
    logic        [7:0]  result;
    logic               result_valid;
    logic signed [21:0] raw_sum;
    logic               sat_flag;
    logic               weights_ready;
    logic        [7:0]  drop_count;

    modport master (
        output in_vector, in_valid, w_data, w_valid, bias,
        input  result, result_valid, raw_sum, sat_flag, weights_ready, drop_count
    );

    modport slave (
        input  in_vector, in_valid, w_data, w_valid, bias,
        output result, result_valid, raw_sum, sat_flag, weights_ready, drop_count
    );
endinterface

// File: rtl/conv3x3_mac.sv
// Three-stage 3x3 multiply-accumulate with bias, arithmetic shift, optional ReLU
// and unsigned 8-bit saturation; kernel weights arrive serially.
module conv3x3_mac #(
    parameter int unsigned SHIFT = 0,
    parameter bit          RELU  = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    conv3x3_mac_if.slave  bus
);
    logic signed [7:0]  weight [9];
    logic        [3:0]  w_idx;
    logic               weights_ready;
    logic        [7:0]  drop_count;
    logic               accept;

    logic               s1_valid;
    logic signed [16:0] s1_prod [9];
    logic               s2_valid;
    logic signed [18:0] s2_row [3];
    logic signed [15:0] s2_bias;

    logic signed [21:0] total;
    logic signed [21:0] shifted;
    logic        [7:0]  sat_result;
    logic               sat_hit;

    logic        [7:0]  result;
    logic               result_valid;
    logic signed [21:0] raw_sum;
    logic               sat_flag;

    assign accept = bus.in_valid & weights_ready;

    // A write to slot 8 completes the kernel; any other write (including the
    // first write of a reload) leaves the kernel incomplete.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_idx         <= 4'd0;
            weights_ready <= 1'b0;
            drop_count    <= 8'd0;
            for (int i = 0; i < 9; i++) weight[i] <= 8'sd0;
        end else begin
            if (bus.w_valid) begin
                weight[w_idx] <= bus.w_data;
                w_idx         <= (w_idx == 4'd8) ? 4'd0 : w_idx + 4'd1;
                weights_ready <= (w_idx == 4'd8);
            end
            if (bus.in_valid && !weights_ready) drop_count <= drop_count + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            result_valid <= 1'b0;
            result       <= 8'd0;
            raw_sum      <= 22'sd0;
            sat_flag     <= 1'b0;
        end else begin
            s1_valid     <= accept;
            s2_valid     <= s1_valid;
            result_valid <= s2_valid;
            if (s2_valid) begin
                result   <= sat_result;
                raw_sum  <= total;
                sat_flag <= sat_hit;
            end
        end
    end

    // Datapath registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < 9; i++)
                s1_prod[i] <= 17'($signed({1'b0, bus.in_vector[8*i +: 8]})) * 17'(weight[i]);
        end
        if (s1_valid) begin
            for (int r = 0; r < 3; r++)
                s2_row[r] <= 19'(s1_prod[3*r]) + 19'(s1_prod[3*r+1]) + 19'(s1_prod[3*r+2]);
            s2_bias <= bus.bias;
        end
    end

    always_comb begin
        total      = 22'(s2_row[0]) + 22'(s2_row[1]) + 22'(s2_row[2]) + 22'(s2_bias);
        shifted    = total >>> SHIFT;
        sat_result = 8'd0;
        sat_hit    = 1'b0;
        if (shifted[21]) begin
            sat_result = 8'd0;
            sat_hit    = ~RELU;
        end else if (shifted > 22'sd255) begin
            sat_result = 8'd255;
            sat_hit    = 1'b1;
        end else begin
            sat_result = shifted[7:0];
        end
    end

    assign bus.result        = result;
    assign bus.result_valid  = result_valid;
    assign bus.raw_sum       = raw_sum;
    assign bus.sat_flag      = sat_flag;
    assign bus.weights_ready = weights_ready;
    assign bus.drop_count    = drop_count;
endmodule

// File: tb/tb_conv3x3_mac.sv
// Bench for conv3x3_mac: three instances (SHIFT/RELU = 0/1, 0/0, 12/0) share one
// stimulus stream and are checked every cycle against an arithmetic model.
module tb_conv3x3_mac;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [71:0] in_vector = '0;
    logic        in_valid  = 1'b0;
    logic [7:0]  w_data    = '0;
    logic        w_valid   = 1'b0;
    logic [15:0] bias      = '0;

    logic               rv  [3];
    logic        [7:0]  res [3];
    logic               sat [3];
    logic signed [21:0] raw [3];
    logic               wr  [3];
    logic        [7:0]  dc  [3];

    localparam int SH [3] = '{0, 0, 12};
    localparam bit RL [3] = '{1'b1, 1'b0, 1'b0};

    for (genvar g = 0; g < 3; g++) begin : gd
        conv3x3_mac_if bus ();
        assign bus.in_vector = in_vector;
        assign bus.in_valid  = in_valid;
        assign bus.w_data    = w_data;
        assign bus.w_valid   = w_valid;
        assign bus.bias      = bias;
        assign rv[g]  = bus.result_valid;
        assign res[g] = bus.result;
        assign sat[g] = bus.sat_flag;
        assign raw[g] = bus.raw_sum;
        assign wr[g]  = bus.weights_ready;
        assign dc[g]  = bus.drop_count;
        conv3x3_mac #(.SHIFT(SH[g]), .RELU(RL[g])) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    end

    typedef struct {
        int due;
        int raw;
        int res [3];
        int sat [3];
    } exp_t;

    exp_t q [$];
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   started = 1'b0;

    int h_res [3];
    int h_sat [3];
    int h_raw;

    logic signed [7:0] mw [9];
    logic signed [7:0] mw_n [9];
    int midx, midx_n, mdrop, mdrop_n;
    bit mrdy, mrdy_n;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %0d, want %0d", nm, cyc, act, expv);
        end
    endtask

    function automatic void post(input int total, input int sh, input bit relu,
                                 output int r, output int s);
        int v;
        v = total >>> sh;
        if (v < 0) begin
            r = 0;
            s = relu ? 0 : 1;
        end else if (v > 255) begin
            r = 255;
            s = 1;
        end else begin
            r = v;
            s = 0;
        end
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 9; i++) mw[i] = 8'sd0;
        midx = 0; mdrop = 0; mrdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            h_res[k] = 0;
            h_sat[k] = 0;
        end
        h_raw = 0;
        q.delete();
    endtask

    // One cycle of stimulus; the model decides acceptance from this cycle's state.
    task automatic step(input bit iv, input logic [71:0] win, input bit wv, input logic [7:0] wd);
        exp_t e;
        int   total;
        in_valid  = iv;
        in_vector = win;
        w_valid   = wv;
        w_data    = wd;
        mw_n = mw; midx_n = midx; mdrop_n = mdrop; mrdy_n = mrdy;
        if (iv) begin
            if (mrdy) begin
                total = int'($signed(bias));
                for (int i = 0; i < 9; i++) total += int'(win[8*i +: 8]) * int'(mw[i]);
                e.due = cyc + 3;
                e.raw = total;
                for (int k = 0; k < 3; k++) post(total, SH[k], RL[k], e.res[k], e.sat[k]);
                q.push_back(e);
            end else begin
                mdrop_n = (mdrop + 1) % 256;
            end
        end
        if (wv) begin
            mw_n[midx] = wd;
            mrdy_n     = (midx == 8);
            midx_n     = (midx == 8) ? 0 : midx + 1;
        end
        @(posedge clk);
        #1;
        mw = mw_n; midx = midx_n; mdrop = mdrop_n; mrdy = mrdy_n;
        in_valid = 1'b0;
        w_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 72'd0, 1'b0, 8'd0);
    endtask

    task automatic load_all(input logic [7:0] wd);
        for (int i = 0; i < 9; i++) step(1'b0, 72'd0, 1'b1, wd);
    endtask

    task automatic pulse_reset();
        in_valid = 1'b0;
        w_valid  = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (started) begin
            bit ev;
            ev = (q.size() > 0) && (q[0].due == cyc);
            if (q.size() > 0 && q[0].due < cyc) begin
                chk("result_late", 0, 1);
                void'(q.pop_front());
            end
            if (ev) begin
                h_raw = q[0].raw;
                for (int k = 0; k < 3; k++) begin
                    h_res[k] = q[0].res[k];
                    h_sat[k] = q[0].sat[k];
                end
                void'(q.pop_front());
            end
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("result_valid[%0d]", k), int'(rv[k]), int'(ev));
                chk($sformatf("result[%0d]", k), int'(res[k]), h_res[k]);
                chk($sformatf("sat_flag[%0d]", k), int'(sat[k]), h_sat[k]);
                chk($sformatf("raw_sum[%0d]", k), int'(raw[k]), h_raw);
                chk($sformatf("weights_ready[%0d]", k), int'(wr[k]), int'(mrdy));
                chk($sformatf("drop_count[%0d]", k), int'(dc[k]), mdrop);
            end
        end
    end

    logic [71:0] win19, win_ff, w;

    initial begin
        for (int i = 0; i < 9; i++) win19[8*i +: 8] = 8'(i + 1);
        win_ff = {9{8'hFF}};
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        started = 1'b1;

        // window before any kernel is dropped
        step(1'b1, win19, 1'b0, 8'd0);
        idle(4);
        chk("lit_drop_count", int'(dc[0]), 1);
        chk("lit_no_result", int'(res[0]), 0);

        for (int i = 0; i < 8; i++) step(1'b0, 72'd0, 1'b1, 8'h01);
        chk("lit_ready_before_9th", int'(wr[0]), 0);
        step(1'b0, 72'd0, 1'b1, 8'h01);
        chk("lit_ready_after_9th", int'(wr[0]), 1);

        step(1'b1, win19, 1'b0, 8'd0);
        idle(4);
        chk("lit_identity_result", int'(res[0]), 45);
        chk("lit_identity_raw", int'(raw[0]), 45);
        chk("lit_identity_sat", int'(sat[0]), 0);

        // reload starts on the same cycle as an accepted window
        step(1'b1, win19, 1'b1, 8'hFF);
        chk("lit_ready_falls", int'(wr[0]), 0);
        idle(4);
        chk("lit_old_kernel_result", int'(res[0]), 45);
        for (int i = 0; i < 8; i++) step(1'b0, 72'd0, 1'b1, 8'hFF);
        chk("lit_ready_reload", int'(wr[0]), 1);

        step(1'b1, win19, 1'b0, 8'd0);
        idle(4);
        chk("lit_neg_raw", int'(raw[0]), -45);
        chk("lit_relu_result", int'(res[0]), 0);
        chk("lit_relu_sat", int'(sat[0]), 0);
        chk("lit_norelu_result", int'(res[1]), 0);
        chk("lit_norelu_sat", int'(sat[1]), 1);

        load_all(8'd127);
        step(1'b1, win_ff, 1'b0, 8'd0);
        idle(4);
        chk("lit_max_raw", int'(raw[1]), 291465);
        chk("lit_max_result_sh0", int'(res[1]), 255);
        chk("lit_max_sat_sh0", int'(sat[1]), 1);
        chk("lit_max_result_sh12", int'(res[2]), 71);
        chk("lit_max_sat_sh12", int'(sat[2]), 0);

        load_all(8'd0);
        bias = 16'hFFFB;
        step(1'b1, win19, 1'b0, 8'd0);
        idle(4);
        chk("lit_bias_neg_result", int'(res[0]), 0);
        chk("lit_bias_neg_raw", int'(raw[0]), -5);
        bias = 16'd200;
        step(1'b1, win19, 1'b0, 8'd0);
        idle(4);
        chk("lit_bias_pos_result", int'(res[0]), 200);
        chk("lit_bias_pos_raw", int'(raw[0]), 200);

        // stream with a distinct kernel and mixed-sign bias
        for (int i = 0; i < 9; i++) step(1'b0, 72'd0, 1'b1, (i % 2 == 0) ? 8'(i + 1) : 8'(-(i + 1)));
        bias = 16'hFF00;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 9; i++) w[8*i +: 8] = 8'($urandom_range(0, 255));
            step(1'b1, w, 1'b0, 8'd0);
        end
        idle(5);

        step(1'b1, win19, 1'b0, 8'd0);
        step(1'b1, win_ff, 1'b0, 8'd0);
        pulse_reset();
        chk("lit_reset_ready", int'(wr[0]), 0);
        chk("lit_reset_result", int'(res[0]), 0);
        chk("lit_reset_valid", int'(rv[0]), 0);
        idle(5);
        chk("lit_reset_drop", int'(dc[0]), 0);
        chk("lit_reset_raw", int'(raw[0]), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
